module_mux_scan: RTL



---
 rtl/module_mux_scan_pkg.sv | 37 +++
 rtl/module_mux_scan_if.sv | 30 +++
 rtl/module_mux_scan_prescaler.sv | 29 ++
 rtl/module_mux_scan.sv | 105 ++++++++++
 4 files changed

// File: rtl/module_mux_scan_pkg.sv
// Shared types and helpers for the time-multiplexed channel scanner.
// Provides the scan mode enum, the select-width rule and the masked round-robin search.
package module_mux_pkg;

  typedef enum logic {
    MODE_AUTO   = 1'b0,
    MODE_MANUAL = 1'b1
  } mode_e;

  // Channel index width; a 1-bit index is kept even where clog2 would give 0.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Next set bit of mask strictly above cur, wrapping at n. Returns cur when no
  // other channel is enabled, so a lone or empty mask leaves the pointer alone.
  function automatic logic [3:0] next_enabled(input logic [15:0] mask,
                                              input logic [3:0]  cur,
                                              input int          n);
    logic [3:0] res;
    logic       found;
    int         idx;
    res   = cur;
    found = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i <= n && !found) begin
        idx = (int'(cur) + i) % n;
        if (mask[idx[3:0]]) begin
          res   = idx[3:0];
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/module_mux_scan_if.sv
// Channel bus of the scanner: flattened channel data, mask and mode in; selected data,
// index, one-hot enable and advance strobe out.
interface module_mux_scan_if
  import module_mux_pkg::*;
#(
  parameter int ANCHO = 8,
  parameter int N_CH  = 4
);
  localparam int SEL_W = sel_width(N_CH);

  logic [N_CH*ANCHO-1:0] data_i;
  logic [N_CH-1:0]       en_mask_i;
  mode_e                 mode_i;
  logic [SEL_W-1:0]      sel_i;
  logic [ANCHO-1:0]      out_o;
  logic [SEL_W-1:0]      sel_o;
  logic [N_CH-1:0]       an_o;
  logic                  adv_o;

  modport master (
    output data_i, en_mask_i, mode_i, sel_i,
    input  out_o, sel_o, an_o, adv_o
  );

  modport slave (
    input  data_i, en_mask_i, mode_i, sel_i,
    output out_o, sel_o, an_o, adv_o
  );

endinterface

// File: rtl/module_mux_scan_prescaler.sv
// Dwell prescaler: counts 0..DWELL-1 and pulses tick for one cycle at terminal count.
// clr holds the count at 0 (manual mode) and suppresses the tick.
module module_prescaler #(
  parameter int DWELL = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/module_mux_scan.sv
// N:1 time-multiplexed channel scanner with auto/manual modes and masked-channel skipping.
// Optional anti-ghosting blanking of an_o on channel change when MUX_BLANK_EN is defined.
module module_mux_scan
  import module_mux_pkg::*;
#(
  parameter int ANCHO = 8,
  parameter int N_CH  = 4,
  parameter int DWELL = 50000,
  parameter int BLANK = 2
) (
  input logic              clk,
  input logic              rst,
  module_mux_scan_if.slave bus
);
  localparam int SEL_W = sel_width(N_CH);

  logic [SEL_W-1:0] ptr, ptr_nxt, cur;
  logic [SEL_W-1:0] sel_q;
  logic [ANCHO-1:0] out_q, out_nxt;
  logic [N_CH-1:0]  an_q, an_nxt;
  logic             adv_q;
  logic             tick, clr, chg, blanking;

  assign clr = (bus.mode_i == MODE_MANUAL);

  module_prescaler #(.DWELL(DWELL)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  // cur is the channel the outputs will show next; manual mode bypasses the pointer
  // so sel_o follows sel_i with one cycle of latency.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    cur     = ptr;
    ptr_nxt = ptr;
    if (bus.mode_i == MODE_MANUAL) begin
      cur     = bus.sel_i;
      ptr_nxt = bus.sel_i;
    end else if (tick) begin
      ptr_nxt = SEL_W'(next_enabled(16'(bus.en_mask_i), 4'(ptr), N_CH));
    end
  end

  // Out-of-range or masked channels match nothing and so drive zero data and no enable.
  always_comb begin
    out_nxt = '0;
    an_nxt  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (cur == SEL_W'(k) && bus.en_mask_i[k]) begin
        out_nxt   = bus.data_i[k*ANCHO +: ANCHO];
        an_nxt[k] = 1'b1;
      end
    end
  end

  assign chg = (cur != sel_q);

`ifdef MUX_BLANK_EN
  localparam int               BLANK_W    = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'((BLANK > 0) ? BLANK - 1 : 0);

  // Remaining blank cycles after the adv_o cycle itself.
  logic [BLANK_W-1:0] blank_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      blank_cnt <= '0;
    end else if (chg && BLANK > 0) begin
      blank_cnt <= BLANK_LOAD;
    end else if (blank_cnt != '0) begin
      blank_cnt <= blank_cnt - BLANK_W'(1);
    end
  end

  assign blanking = (chg && BLANK > 0) || (blank_cnt != '0);
`else
  assign blanking = 1'b0;
`endif

  // NOTE: only control/output flops exist here, so all of them take the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      sel_q <= '0;
      out_q <= '0;
      an_q  <= '0;
      adv_q <= 1'b0;
    end else begin
      ptr   <= ptr_nxt;
      sel_q <= cur;
      out_q <= out_nxt;
      an_q  <= blanking ? '0 : an_nxt;
      adv_q <= chg;
    end
  end

  assign bus.sel_o = sel_q;
  assign bus.out_o = out_q;
  assign bus.an_o  = an_q;
  assign bus.adv_o = adv_q;

endmodule
